alarm_ctrl: RTL and testbench

- Downstream consumer of the time-of-day counter; watches its hrs/min/sec outputs and drives a daily alarm with ring timeout and limited snooze.
- Holds a programmable alarm time, an arm/disarm state, a ring/snooze state machine and a shared duration counter.
- The upstream counter advances one second per clk, so every duration here is counted in clk cycles, where 1 cycle = 1 timer second.

---
 rtl/alarm_pkg.sv | 9 +
 rtl/alarm_time_reg.sv | 38 +++
 rtl/alarm_ctrl.sv | 128 ++++++++++++
 tb/tb_alarm_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and limits for the daily alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_state_t;

  localparam logic [4:0] HRS_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/alarm_time_reg.sv
// Range-checked alarm-time register; a bad load is dropped and flagged for one cycle.
module alarm_time_reg
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_hrs,
  input  logic [5:0] set_min,
  output logic [4:0] al_hrs,
  output logic [5:0] al_min,
  output logic       set_err
);

  logic in_range;

  assign in_range = (set_hrs <= HRS_MAX) && (set_min <= MIN_MAX);

  // Load on a valid request, otherwise keep the old time and pulse set_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      al_hrs  <= '0;
      al_min  <= '0;
      set_err <= 1'b0;
    end else begin
      set_err <= 1'b0;
      if (set_en) begin
        if (in_range) begin
          al_hrs <= set_hrs;
          al_min <= set_min;
        end else begin
          set_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Daily alarm: arm/disarm, ring with timeout, limited snooze. One clk = one timer second.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       set_en,
  input  logic [4:0] set_hrs,
  input  logic [5:0] set_min,
  input  logic       arm,
  input  logic       disarm,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic       armed,
  output logic       snoozing,
  output logic [2:0] snooze_left,
  output logic       missed,
  output logic       set_err
);

  // One counter serves both ring and snooze durations, so it is sized for the longer one.
  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_SECS - 1);
  localparam logic [2:0]    SNZ_MAX   = 3'(MAX_SNOOZE);

  alarm_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    snz_cnt, snz_nxt;
  logic          missed_nxt;
  logic [4:0]    al_hrs;
  logic [5:0]    al_min;
  logic          match;

  alarm_time_reg u_time (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_hrs (set_hrs),
    .set_min (set_min),
    .al_hrs  (al_hrs),
    .al_min  (al_min),
    .set_err (set_err)
  );

  // al_* still holds the pre-load value during a load cycle, so a match sees the old time.
  assign match = (hrs == al_hrs) && (min == al_min) && (sec == 6'd0);

  // Next state, counter and snooze bookkeeping; priority disarm > stop > snooze > match/timeout.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    snz_nxt    = snz_cnt;
    missed_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (disarm)     state_nxt = IDLE;
        else if (match) state_nxt = RINGING;
      end
      RINGING: begin
        if (disarm)    state_nxt = IDLE;
        else if (stop) state_nxt = ARMED;
        else if (snooze && (snz_cnt < SNZ_MAX)) begin
          state_nxt = SNOOZE;
          snz_nxt   = snz_cnt + 3'd1;
          cnt_nxt   = '0;
        end else if (cnt == RING_LAST) begin
          state_nxt  = ARMED;
          missed_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SNOOZE: begin
        if (disarm)    state_nxt = IDLE;
        else if (stop) state_nxt = ARMED;
        else if (cnt == SNZ_LAST) begin
          state_nxt = RINGING;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Leaving the ring/snooze cycle starts the next event fresh.
    if (state_nxt == IDLE || state_nxt == ARMED) begin
      cnt_nxt = '0;
      snz_nxt = '0;
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      snz_cnt     <= '0;
      ring        <= 1'b0;
      armed       <= 1'b0;
      snoozing    <= 1'b0;
      missed      <= 1'b0;
      snooze_left <= SNZ_MAX;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      snz_cnt     <= snz_nxt;
      ring        <= (state_nxt == RINGING);
      armed       <= (state_nxt != IDLE);
      snoozing    <= (state_nxt == SNOOZE);
      missed      <= missed_nxt;
      snooze_left <= SNZ_MAX - snz_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a countdown-based model.
module tb_alarm_ctrl;

  localparam int RS = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] hrs = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       set_en = 1'b0;
  logic [4:0] set_hrs = '0;
  logic [5:0] set_min = '0;
  logic       arm = 1'b0, disarm = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic       ring, armed, snoozing, missed, set_err;
  logic [2:0] snooze_left;

  int n_cmp = 0;
  int n_err = 0;

  // Model: alarm on/off, remaining ring and snooze seconds, snoozes used.
  int m_on, m_ring, m_snz, m_used, m_missed, m_err, m_ah, m_am;

  alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec),
    .set_en(set_en), .set_hrs(set_hrs), .set_min(set_min),
    .arm(arm), .disarm(disarm), .stop(stop), .snooze(snooze),
    .ring(ring), .armed(armed), .snoozing(snoozing), .snooze_left(snooze_left),
    .missed(missed), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit match;
    match = (int'(hrs) == m_ah) && (int'(min) == m_am) && (sec == 0);
    if (rst) begin
      m_on = 0; m_ring = 0; m_snz = 0; m_used = 0;
      m_missed = 0; m_err = 0; m_ah = 0; m_am = 0;
      return;
    end
    m_err = 0;
    m_missed = 0;
    if (set_en) begin
      if (set_hrs <= 23 && set_min <= 59) begin
        m_ah = set_hrs;
        m_am = set_min;
      end else m_err = 1;
    end
    if (m_on == 0) begin
      if (arm) m_on = 1;
    end else if (disarm) begin
      m_on = 0; m_ring = 0; m_snz = 0; m_used = 0;
    end else if (m_ring > 0) begin
      if (stop) begin
        m_ring = 0; m_used = 0;
      end else if (snooze && m_used < MS) begin
        m_ring = 0; m_snz = SS; m_used++;
      end else begin
        m_ring--;
        if (m_ring == 0) begin
          m_missed = 1; m_used = 0;
        end
      end
    end else if (m_snz > 0) begin
      if (stop) begin
        m_snz = 0; m_used = 0;
      end else begin
        m_snz--;
        if (m_snz == 0) m_ring = RS;
      end
    end else if (match) begin
      m_ring = RS;
    end
  endfunction

  // One clock: model advances on the same inputs the DUT samples, outputs checked just after.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("ring",        int'(ring),        int'(m_ring > 0));
    chk("armed",       int'(armed),       m_on);
    chk("snoozing",    int'(snoozing),    int'(m_snz > 0));
    chk("snooze_left", int'(snooze_left), MS - m_used);
    chk("missed",      int'(missed),      m_missed);
    chk("set_err",     int'(set_err),     m_err);
    rst = 0; set_en = 0; arm = 0; disarm = 0; stop = 0; snooze = 0;
  endtask

  task automatic match_tick(input int h, input int m);
    hrs = 5'(h); min = 6'(m); sec = 6'd0;
    tick();
    sec = 6'd1;
  endtask

  // Run out a snooze; a stuck snooze shows up as a failed comparison.
  task automatic wait_snooze();
    int n = 1;
    for (int i = 0; i < SS + 20 && snoozing; i++) begin
      tick();
      if (snoozing) n++;
    end
    chk("snz_len", n, SS);
    chk("re_ring", int'(ring), 1);
  endtask

  initial begin
    int n;
    rst = 1;
    tick();
    chk("rst_sl", int'(snooze_left), MS);
    hrs = 5'd12; min = 6'd0; sec = 6'd1;

    // Load 6:30, arm, ring to timeout.
    set_en = 1; set_hrs = 5'd6; set_min = 6'd30;
    tick();
    arm = 1;
    tick();
    match_tick(6, 30);
    chk("ring_on", int'(ring), 1);
    n = 1;
    for (int i = 0; i < RS + 10 && ring; i++) begin
      tick();
      if (ring) n++;
      else begin
        chk("missed_pulse", int'(missed), 1);
        chk("armed_after", int'(armed), 1);
      end
    end
    chk("ring_len", n, RS);

    // Snooze at ring cycle 5, then re-ring.
    match_tick(6, 30);
    repeat (4) tick();
    snooze = 1;
    tick();
    chk("snz1", int'(snoozing), 1);
    chk("snz1_ring", int'(ring), 0);
    chk("snz1_left", int'(snooze_left), 2);
    wait_snooze();

    // Use up the remaining snoozes; the extra one is ignored.
    snooze = 1; tick(); wait_snooze();
    snooze = 1; tick(); wait_snooze();
    snooze = 1; tick();
    chk("snz4_ring", int'(ring), 1);
    chk("snz4_left", int'(snooze_left), 0);
    stop = 1; tick();
    chk("stop_armed", int'(armed), 1);
    chk("stop_left", int'(snooze_left), MS);

    // Rejected loads keep 6:30.
    set_en = 1; set_hrs = 5'd24; set_min = 6'd0; tick();
    chk("err_hrs", int'(set_err), 1);
    set_en = 1; set_hrs = 5'd5; set_min = 6'd60; tick();
    chk("err_min", int'(set_err), 1);
    match_tick(6, 30);
    chk("old_match", int'(ring), 1);

    // Triple pulse while ringing: disarm wins.
    disarm = 1; stop = 1; snooze = 1; tick();
    chk("triple_armed", int'(armed), 0);
    chk("triple_ring", int'(ring), 0);

    // Load 7:00 in the 6:30 match cycle.
    arm = 1; tick();
    set_en = 1; set_hrs = 5'd7; set_min = 6'd0;
    match_tick(6, 30);
    chk("load_match", int'(ring), 1);
    stop = 1; tick();
    match_tick(6, 30);
    chk("no_old", int'(ring), 0);
    match_tick(7, 0);
    chk("new_match", int'(ring), 1);
    snooze = 1; tick();
    chk("pre_rst_snz", int'(snoozing), 1);
    rst = 1; tick();
    chk("rst_armed", int'(armed), 0);
    chk("rst_snz", int'(snoozing), 0);

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      rst    = ($urandom_range(0, 1999) == 0);
      arm    = ($urandom_range(0, 19) == 0);
      disarm = ($urandom_range(0, 399) == 0);
      stop   = ($urandom_range(0, 299) == 0);
      snooze = ($urandom_range(0, 39) == 0);
      set_en = ($urandom_range(0, 199) == 0);
      set_hrs = 5'($urandom_range(0, 31));
      set_min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 29) == 0) begin
        hrs = 5'(m_ah); min = 6'(m_am); sec = 6'd0;
      end else begin
        hrs = 5'($urandom_range(0, 23));
        min = 6'($urandom_range(0, 59));
        sec = 6'($urandom_range(0, 59));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
